// File: rtl/alu_rotate_sequencer.sv
// alu_rotate_sequencer
//
// Multi-cycle rotate unit. A command (operand, amount, direction) is taken
// over a valid/ready handshake. The unit then applies a single-bit
// rotate-right once per clock until the effective amount is used up. A left
// rotate is turned into a right rotate by the complementary amount, so only
// one datapath direction exists.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The unit never drops a result while
// out_valid is high and out_ready is low, and it ignores in_valid while
// in_ready is low. in_ready depends combinationally on out_ready, so a
// finished result and a new command can transfer on the same edge.
//
// Ports
//   clk        : clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   in_valid   : command valid
//   in_ready   : unit can take a command this cycle
//   in_data    : N-bit operand
//   in_amount  : rotate amount, 0..N-1
//   in_left    : 1 = rotate left, 0 = rotate right
//   out_valid  : result valid (DONE state)
//   out_ready  : consumer takes the result
//   out_data   : rotated result, always driven from the data register
//   busy       : unit is in ROTATE or DONE
//   dbg_state  : current FSM state encoding, for observation only

module alu_rotate_sequencer #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_amount,
    input  logic          in_left,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q,  data_d;
    logic [SW-1:0] count_q, count_d;

    logic [SW-1:0] eff_amount;
    logic          accept;

    // Left by a equals right by (N - a) mod N; with N a power of two the
    // modulo is just the SW-bit truncation of the negation.
    assign eff_amount = in_left ? (SW'(0) - in_amount) : in_amount;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    count_d = eff_amount;
                    state_d = (eff_amount != '0) ? ROTATE : DONE;
                end
            end

            ROTATE: begin
                data_d  = {data_q[0], data_q[N-1:1]};
                count_d = count_q - 1'b1;
                // Exit on the last step so count_q never wraps below zero.
                if (count_q == SW'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        // Result leaves and the next command enters on the
                        // same edge, keeping a bubble-free stream.
                        data_d  = in_data;
                        count_d = eff_amount;
                        state_d = (eff_amount != '0) ? ROTATE : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
